// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order memory requests, response FIFO and
// branch redirect with discard of responses still in flight.
module fetch_unit #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DEPTH         = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    imem_rsp_data,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = PW + 2;

  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] rsp_pc;
  logic [DATA_WIDTH-1:0]    word_q [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_q   [DEPTH];
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            wr_ptr;
  logic [CW-1:0]            occ;
  logic [CW-1:0]            inflight;
  logic [CW-1:0]            discard;
  logic [SW-1:0]            credit;
  logic                     deq;
  logic                     req_fire;
  logic                     keep;

  // Credit counts in-flight plus buffered words so every kept response has a slot.
  always_comb begin
    instr_valid    = (occ != '0) && !redirect;
    deq            = instr_valid && instr_ready;
    credit         = SW'(inflight) + SW'(occ) - SW'(deq);
    imem_req_valid = !rst && !redirect && (credit < SW'(DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;
    keep           = imem_rsp_valid && !redirect && (discard == '0);
  end

  assign imem_req_addr = pc;
  assign instr         = word_q[rd_ptr];
  assign instr_pc      = pc_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      occ      <= '0;
      inflight <= '0;
      discard  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        word_q[PW'(i)] <= '0;
        pc_q[PW'(i)]   <= RESET_PC;
      end
    end else if (redirect) begin
      // Everything still outstanding belongs to the wrong path.
      pc       <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
      rsp_pc   <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
      occ      <= '0;
      rd_ptr   <= wr_ptr;
      inflight <= inflight - CW'(imem_rsp_valid);
      discard  <= inflight - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc <= pc + ADDRESS_WIDTH'(4);
      end
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
      if (keep) begin
        word_q[wr_ptr] <= imem_rsp_data;
        pc_q[wr_ptr]   <= rsp_pc;
        wr_ptr         <= wr_ptr + PW'(1);
        rsp_pc         <= rsp_pc + ADDRESS_WIDTH'(4);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      occ <= occ + CW'(keep) - CW'(deq);
      assert (!(keep && (occ == CW'(DEPTH))));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for reset/stream/redirect,
// hand-written sequences for backpressure, slow memory and PC wrap.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (RESET_PC = 0)
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  // wrap instance (RESET_PC = 0xFFFFFFF8)
  logic        w_rst = 1'b1;
  logic        w_req_valid;
  logic        w_req_ready = 1'b1;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = '0;
  logic        w_instr_valid;
  logic        w_instr_ready = 1'b1;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;

  fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(w_rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr), .instr_pc(w_instr_pc)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  // Main memory: fixed latency 1..3 cycles, in order, always ready.
  int          lat = 1;
  logic [2:0]  mv = '0;
  logic [31:0] ma [3];
  always @(posedge clk) begin
    if (rst) begin
      mv <= '0;
    end else begin
      mv    <= {mv[1:0], imem_req_valid && imem_req_ready};
      ma[0] <= imem_req_addr;
      ma[1] <= ma[0];
      ma[2] <= ma[1];
    end
  end
  assign imem_rsp_valid = mv[lat-1];
  assign imem_rsp_data  = imem_rsp_valid ? word_of(ma[lat-1]) : 32'h0;

  // Wrap-instance memory: 1-cycle latency.
  logic        wv = 1'b0;
  logic [31:0] wa = '0;
  always @(posedge clk) begin
    if (w_rst) begin
      wv <= 1'b0;
    end else begin
      wv <= w_req_valid && w_req_ready;
      wa <= w_req_addr;
    end
  end
  assign w_rsp_valid = wv;
  assign w_rsp_data  = wv ? word_of(wa) : 32'h0;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        track    = 1'b0;
  logic [31:0] exp_pc   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One cycle on the main instance; consumed instructions are checked in order.
  task automatic tick(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    rst = r; instr_ready = rdy; redirect = rd; redirect_pc = rpc;
    #1;
    if (track && instr_valid && instr_ready) begin
      check("stream_pc", instr_pc, exp_pc);
      check("stream_word", instr, word_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic tickw(input logic r);
    @(negedge clk);
    w_rst = r;
    #1;
  endtask

  typedef struct {
    logic        r, rdy, rd;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic        chk_head;
    logic [31:0] e_pc;
    logic [31:0] e_word;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                              input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                              input logic chk_head, input logic [31:0] e_pc, input logic [31:0] e_word);
    vec_t v;
    v.r = r; v.rdy = 1'b1; v.rd = rd; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
    v.chk_head = chk_head; v.e_pc = e_pc; v.e_word = e_word;
    return v;
  endfunction

  vec_t vecs [12];
  int   cnt;

  initial begin
    // reset, stream from 0, then redirect to 0x203 coincident with a response
    vecs[0]  = mk(1, 0, 32'h0,   0, 32'h0,   0, 1, 32'h0,   32'h0);
    vecs[1]  = mk(0, 0, 32'h0,   1, 32'h0,   0, 0, 32'h0,   32'h0);
    vecs[2]  = mk(0, 0, 32'h0,   1, 32'h4,   0, 0, 32'h0,   32'h0);
    vecs[3]  = mk(0, 0, 32'h0,   1, 32'h8,   1, 1, 32'h0,   word_of(32'h0));
    vecs[4]  = mk(0, 0, 32'h0,   1, 32'hC,   1, 1, 32'h4,   word_of(32'h4));
    vecs[5]  = mk(0, 0, 32'h0,   1, 32'h10,  1, 1, 32'h8,   word_of(32'h8));
    vecs[6]  = mk(0, 0, 32'h0,   1, 32'h14,  1, 1, 32'hC,   word_of(32'hC));
    vecs[7]  = mk(0, 1, 32'h203, 0, 32'h18,  0, 0, 32'h0,   32'h0);
    vecs[8]  = mk(0, 0, 32'h0,   1, 32'h200, 0, 0, 32'h0,   32'h0);
    vecs[9]  = mk(0, 0, 32'h0,   1, 32'h204, 0, 0, 32'h0,   32'h0);
    vecs[10] = mk(0, 0, 32'h0,   1, 32'h208, 1, 1, 32'h200, word_of(32'h200));
    vecs[11] = mk(0, 0, 32'h0,   1, 32'h20C, 1, 1, 32'h204, word_of(32'h204));

    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].r, vecs[i].rdy, vecs[i].rd, vecs[i].rpc);
      check($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_req));
      check($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
      check($sformatf("v%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_iv));
      if (vecs[i].chk_head) begin
        check($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].e_pc);
        check($sformatf("v%0d_instr", i), instr, vecs[i].e_word);
      end
    end

    // backpressure: 10 cycles stalled, then release
    exp_pc = 32'h208;
    track  = 1'b1;
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 0);
      if (imem_req_valid) cnt++;
    end
    check("hold_req_count", 32'(cnt), 32'd2);
    check("hold_req_valid", 32'(imem_req_valid), 32'd0);
    check("hold_instr_valid", 32'(instr_valid), 32'd1);
    check("hold_instr_pc", instr_pc, 32'h210);
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 0, 0);
      check($sformatf("release%0d_valid", i), 32'(instr_valid), 32'd1);
    end
    check("release_next_pc", exp_pc, 32'h220);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);

    // 3-cycle memory, redirect to 0x100 with 3 requests in flight
    track = 1'b0;
    lat   = 3;
    tick(1, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 32'h100);
    check("slow_redir_rsp", 32'(imem_rsp_valid), 32'd1);
    check("slow_redir_req", 32'(imem_req_valid), 32'd0);
    check("slow_redir_iv", 32'(instr_valid), 32'd0);
    exp_pc = 32'h100;
    track  = 1'b1;
    tick(0, 1, 0, 0);
    check("slow_req_addr", imem_req_addr, 32'h100);
    check("slow_iv_c5", 32'(instr_valid), 32'd0);
    for (int i = 6; i <= 8; i++) begin
      tick(0, 1, 0, 0);
      check($sformatf("slow_iv_c%0d", i), 32'(instr_valid), 32'd0);
    end
    tick(0, 1, 0, 0);
    check("slow_first_valid", 32'(instr_valid), 32'd1);
    for (int i = 0; i < 6; i++) tick(0, 1, 0, 0);
    check("slow_next_pc", exp_pc, 32'h11C);
    track = 1'b0;

    // PC wrap on the second instance, then reset mid-stream
    tickw(1);
    check("w_rst_req_valid", 32'(w_req_valid), 32'd0);
    check("w_rst_req_addr", w_req_addr, 32'hFFFF_FFF8);
    check("w_rst_iv", 32'(w_instr_valid), 32'd0);
    check("w_rst_instr", w_instr, 32'h0);
    check("w_rst_instr_pc", w_instr_pc, 32'hFFFF_FFF8);
    tickw(0);
    check("w_c1_addr", w_req_addr, 32'hFFFF_FFF8);
    tickw(0);
    check("w_c2_iv", 32'(w_instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] epc;
      epc = 32'hFFFF_FFF8 + 32'(4 * i);
      tickw(0);
      check($sformatf("w_c%0d_iv", i + 3), 32'(w_instr_valid), 32'd1);
      check($sformatf("w_c%0d_pc", i + 3), w_instr_pc, epc);
      check($sformatf("w_c%0d_word", i + 3), w_instr, word_of(epc));
    end
    tickw(1);
    check("w_mid_rst_req", 32'(w_req_valid), 32'd0);
    tickw(0);
    check("w_post_rst_req", 32'(w_req_valid), 32'd1);
    check("w_post_rst_addr", w_req_addr, 32'hFFFF_FFF8);
    check("w_post_rst_iv", 32'(w_instr_valid), 32'd0);
    check("w_post_rst_instr", w_instr, 32'h0);
    check("w_post_rst_pc", w_instr_pc, 32'hFFFF_FFF8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
